// File: rtl/demux4_rr_dispatcher.sv
// Round-robin sequencer for a 1-to-4 demux: a one-word holding register feeds
// four channels, with the select and one-hot valid registered alongside the word.
module demux4_rr_dispatcher #(
  parameter int DATA_W    = 8,
  parameter bit SKIP_BUSY = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        out_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  dlv_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] target;
  logic [1:0] cand;
  logic       accept;
  logic       fire;

  assign fire     = busy & out_ready[sel];
  assign in_ready = (state == IDLE) | fire;
  assign accept   = in_valid & in_ready;

  // Scan from the farthest offset down so the nearest ready channel wins.
  always_comb begin
    target = ptr;
    cand   = ptr;
    if (SKIP_BUSY) begin
      for (int k = 3; k >= 0; k--) begin
        cand = ptr + 2'(k);
        if (out_ready[cand]) target = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_valid <= 4'b0000;
      out_data  <= '0;
      busy      <= 1'b0;
      dlv_cnt   <= '0;
    end else begin
      if (fire) dlv_cnt <= dlv_cnt + CNT_W'(1);
      if (accept) begin
        state     <= SEND;
        busy      <= 1'b1;
        sel       <= target;
        ptr       <= target + 2'd1;
        out_data  <= in_data;
        out_valid <= 4'b0001 << target;
      end else if (fire) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Directed bench for demux4_rr_dispatcher: a skipping 16-bit-counter instance
// and a strict-order 4-bit-counter instance share clock and reset.
module tb_demux4_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid_a, in_ready_a, busy_a;
  logic [7:0] in_data_a, out_data_a;
  logic [3:0] out_ready_a, out_valid_a;
  logic [1:0] sel_a;
  logic [15:0] dlv_cnt_a;

  logic       in_valid_b, in_ready_b, busy_b;
  logic [7:0] in_data_b, out_data_b;
  logic [3:0] out_ready_b, out_valid_b;
  logic [1:0] sel_b;
  logic [3:0] dlv_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux4_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .out_ready(out_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .sel(sel_a), .busy(busy_a), .dlv_cnt(dlv_cnt_a)
  );

  demux4_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_ready(out_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .sel(sel_b), .busy(busy_b), .dlv_cnt(dlv_cnt_b)
  );

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] r);
    in_valid_a  = v;
    in_data_a   = d;
    out_ready_a = r;
  endtask

  task automatic applyStimulusB(input logic v, input logic [7:0] d, input logic [3:0] r);
    in_valid_b  = v;
    in_data_b   = d;
    out_ready_b = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d2 [5];
    logic [3:0] ov2 [5];
    logic [3:0] exp_ov;
    d2  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ov2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'h0);
    applyStimulusB(1'b0, 8'h00, 4'h0);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid_a), 32'h0);
    checkOutput("rst_busy", 32'(busy_a), 32'h0);
    checkOutput("rst_sel", 32'(sel_a), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready_a), 32'h1);
    checkOutput("rst_dlv_cnt", 32'(dlv_cnt_a), 32'h0);
    checkOutput("rst_out_data", 32'(out_data_a), 32'h0);
    checkOutput("rst_dlv_cnt_b", 32'(dlv_cnt_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();

    // Back-to-back stream with every channel ready
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, d2[i], 4'hF);
      @(negedge clk);
      checkOutput("b2b_in_ready", 32'(in_ready_a), 32'h1);
      if (i > 0) begin
        checkOutput("b2b_out_valid", 32'(out_valid_a), 32'(ov2[i-1]));
        checkOutput("b2b_out_data", 32'(out_data_a), 32'(d2[i-1]));
        checkOutput("b2b_sel", 32'((i - 1) % 4), 32'(sel_a));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("b2b_last_valid", 32'(out_valid_a), 32'b0001);
    checkOutput("b2b_last_data", 32'(out_data_a), 32'h55);
    checkOutput("b2b_last_sel", 32'(sel_a), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_idle_valid", 32'(out_valid_a), 32'h0);
    checkOutput("b2b_idle_busy", 32'(busy_a), 32'h0);
    checkOutput("b2b_dlv_cnt", 32'(dlv_cnt_a), 32'd5);
    nextCycle();

    // Move ptr to 2, then skip the not-ready channel 2 and land on 3
    applyStimulus(1'b1, 8'h66, 4'hF);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("ptr1_sel", 32'(sel_a), 32'h1);
    checkOutput("ptr1_valid", 32'(out_valid_a), 32'b0010);
    nextCycle();
    applyStimulus(1'b1, 8'h77, 4'b1011);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'b1011);
    @(negedge clk);
    checkOutput("skip_valid", 32'(out_valid_a), 32'b1000);
    checkOutput("skip_sel", 32'(sel_a), 32'h3);
    checkOutput("skip_data", 32'(out_data_a), 32'h77);
    nextCycle();
    applyStimulus(1'b1, 8'h88, 4'hF);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("wrap_ptr_valid", 32'(out_valid_a), 32'b0001);
    checkOutput("wrap_ptr_sel", 32'(sel_a), 32'h0);
    nextCycle();

    // Stall on ch1 with nothing ready, then release only ch1
    applyStimulus(1'b1, 8'h99, 4'b0000);
    @(negedge clk);
    checkOutput("stall_accept_ready", 32'(in_ready_a), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 8'hAA, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(out_valid_a), 32'b0010);
      checkOutput("stall_data", 32'(out_data_a), 32'h99);
      checkOutput("stall_in_ready", 32'(in_ready_a), 32'h0);
      checkOutput("stall_dlv_cnt", 32'(dlv_cnt_a), 32'd8);
      nextCycle();
    end
    applyStimulus(1'b1, 8'hAA, 4'b0010);
    @(negedge clk);
    checkOutput("release_in_ready", 32'(in_ready_a), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'b0010);
    @(negedge clk);
    checkOutput("release_dlv_cnt", 32'(dlv_cnt_a), 32'd9);
    checkOutput("wrapskip_sel", 32'(sel_a), 32'h1);
    checkOutput("wrapskip_data", 32'(out_data_a), 32'hAA);
    checkOutput("wrapskip_valid", 32'(out_valid_a), 32'b0010);
    nextCycle();
    @(negedge clk);
    checkOutput("drain_dlv_cnt", 32'(dlv_cnt_a), 32'd10);
    checkOutput("drain_valid", 32'(out_valid_a), 32'h0);
    nextCycle();

    // Strict order instance: ptr=1 waits on ch1 even though 0,2,3 are ready
    applyStimulusB(1'b1, 8'h01, 4'hF);
    nextCycle();
    applyStimulusB(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("strict_first_valid", 32'(out_valid_b), 32'b0001);
    nextCycle();
    applyStimulusB(1'b1, 8'h5A, 4'b1101);
    @(negedge clk);
    checkOutput("strict_accept_ready", 32'(in_ready_b), 32'h1);
    nextCycle();
    applyStimulusB(1'b0, 8'h00, 4'b1101);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("strict_wait_valid", 32'(out_valid_b), 32'b0010);
      checkOutput("strict_wait_sel", 32'(sel_b), 32'h1);
      checkOutput("strict_wait_in_ready", 32'(in_ready_b), 32'h0);
      checkOutput("strict_wait_dlv", 32'(dlv_cnt_b), 32'd1);
      nextCycle();
    end
    applyStimulusB(1'b0, 8'h00, 4'b0010);
    @(negedge clk);
    checkOutput("strict_fire_ready", 32'(in_ready_b), 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("strict_dlv", 32'(dlv_cnt_b), 32'd2);
    checkOutput("strict_idle_valid", 32'(out_valid_b), 32'h0);
    nextCycle();

    // Sixteen back-to-back words through the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      applyStimulusB(1'b1, 8'(k + 1), 4'hF);
      @(negedge clk);
      checkOutput("cnt_in_ready", 32'(in_ready_b), 32'h1);
      if (k > 0) begin
        exp_ov = 4'b0001 << ((1 + k) % 4);
        checkOutput("cnt_valid", 32'(out_valid_b), 32'(exp_ov));
        checkOutput("cnt_dlv", 32'(dlv_cnt_b), 32'((1 + k) % 16));
      end
      nextCycle();
    end
    applyStimulusB(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("cnt_last_valid", 32'(out_valid_b), 32'b0010);
    checkOutput("cnt_wrapped", 32'(dlv_cnt_b), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("cnt_final", 32'(dlv_cnt_b), 32'd2);
    checkOutput("cnt_idle_busy", 32'(busy_b), 32'h0);
    nextCycle();

    // Asynchronous reset while a word is held
    applyStimulus(1'b1, 8'hC3, 4'b0000);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'b0000);
    #2;
    checkOutput("pre_rst_busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(out_valid_a), 32'h0);
    checkOutput("midrst_busy", 32'(busy_a), 32'h0);
    checkOutput("midrst_sel", 32'(sel_a), 32'h0);
    checkOutput("midrst_in_ready", 32'(in_ready_a), 32'h1);
    checkOutput("midrst_dlv", 32'(dlv_cnt_a), 32'h0);
    checkOutput("midrst_dlv_b", 32'(dlv_cnt_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nextCycle();
    applyStimulus(1'b1, 8'hE1, 4'hF);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 4'hF);
    @(negedge clk);
    checkOutput("postrst_sel", 32'(sel_a), 32'h0);
    checkOutput("postrst_valid", 32'(out_valid_a), 32'b0001);
    checkOutput("postrst_data", 32'(out_data_a), 32'hE1);
    nextCycle();
    @(negedge clk);
    checkOutput("postrst_dlv", 32'(dlv_cnt_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
